// File: rtl/fetch_unit.sv
// fetch_unit: LEGv8 fetch stage owning the PC with req/ack instruction fetch (optional timeout via FETCH_TIMEOUT_EN)
module fetch_unit #(
  parameter int              PC_W     = 64,
  parameter logic [PC_W-1:0] RESET_PC = '0,
  parameter int              TIMEOUT  = 16
) (
  input  logic            clk,
  input  logic            reset,
  output logic            imem_req,
  output logic [PC_W-1:0] imem_addr,
  input  logic            imem_ack,
  input  logic [31:0]     imem_rdata,
  output logic [31:0]     instr,
  output logic [10:0]     opcode,
  output logic            instr_valid,
  input  logic            retire,
  input  logic            pcSrc,
  input  logic [PC_W-1:0] imm_ext,
  output logic [PC_W-1:0] pc,
  output logic            fetch_err
);
`ifdef FETCH_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT + 1);
  typedef enum logic [1:0] {IDLE, REQ, HOLD, ERR} state_t;
  logic [CW-1:0] cnt;
`else
  typedef enum logic [1:0] {IDLE, REQ, HOLD} state_t;
  logic unused_timeout;
  assign unused_timeout = (TIMEOUT > 0);
  assign fetch_err = 1'b0;
`endif
  state_t state;
  logic [PC_W-1:0] next_pc;
  assign next_pc = pcSrc ? pc + (imm_ext << 2) : pc + PC_W'(4);
  assign imem_addr = pc;
  assign opcode = instr[31:21];
  // fetch FSM; handshake flags are registered alongside the state so they never see inputs combinationally
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      pc <= RESET_PC;
      instr <= '0;
      imem_req <= 1'b0;
      instr_valid <= 1'b0;
`ifdef FETCH_TIMEOUT_EN
      fetch_err <= 1'b0;
      cnt <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          state <= REQ;
          imem_req <= 1'b1;
`ifdef FETCH_TIMEOUT_EN
          cnt <= '0;
`endif
        end
        REQ: begin
          if (imem_ack) begin
            instr <= imem_rdata;
            state <= HOLD;
            imem_req <= 1'b0;
            instr_valid <= 1'b1;
          end
`ifdef FETCH_TIMEOUT_EN
          else if (cnt == CW'(TIMEOUT - 1)) begin
            state <= ERR;
            imem_req <= 1'b0;
            fetch_err <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
`endif
        end
        HOLD: begin
          if (retire) begin
            pc <= next_pc;
            state <= REQ;
            imem_req <= 1'b1;
            instr_valid <= 1'b0;
`ifdef FETCH_TIMEOUT_EN
            cnt <= '0;
`endif
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed self-checking bench for fetch_unit
module tb_fetch_unit;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        imem_req;
  logic [63:0] imem_addr;
  logic        imem_ack = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic [31:0] instr;
  logic [10:0] opcode;
  logic        instr_valid;
  logic        retire = 1'b0;
  logic        pcSrc = 1'b0;
  logic [63:0] imm_ext = '0;
  logic [63:0] pc;
  logic        fetch_err;
  int checks = 0;
  int errors = 0;
  logic [31:0] words [4] = '{32'h8B020020, 32'hF84003E1, 32'hCB030041, 32'h17FFFFFE};
  logic [10:0] ops   [4] = '{11'h458, 11'h7C2, 11'h658, 11'h0BF};

  fetch_unit dut (
    .clk(clk), .reset(reset), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata), .instr(instr), .opcode(opcode),
    .instr_valid(instr_valid), .retire(retire), .pcSrc(pcSrc), .imm_ext(imm_ext),
    .pc(pc), .fetch_err(fetch_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // zero-wait fetch from REQ into HOLD
  task automatic fetch(input logic [31:0] w);
    imem_ack = 1'b1;
    imem_rdata = w;
    tick();
    imem_ack = 1'b0;
  endtask

  // retire from HOLD and check the new fetch address
  task automatic retire_to(input string tag, input logic src, input logic [63:0] imm, input logic [63:0] exp);
    retire = 1'b1;
    pcSrc = src;
    imm_ext = imm;
    tick();
    retire = 1'b0;
    pcSrc = 1'b0;
    imm_ext = '0;
    check(tag, imem_addr, exp);
    check({tag, "_req"}, imem_req, 1'b1);
  endtask

  initial begin
    #2;
    check("rst_pc", pc, 64'h0);
    check("rst_instr", instr, 32'h0);
    check("rst_opcode", opcode, 11'h0);
    check("rst_valid", instr_valid, 1'b0);
    check("rst_req", imem_req, 1'b0);
    check("rst_err", fetch_err, 1'b0);
    tick();
    reset = 1'b0;
    check("idle_req", imem_req, 1'b0);
    tick();
    check("first_req", imem_req, 1'b1);
    // zero-wait stream with retire held high: one instruction per two cycles
    retire = 1'b1;
    imem_ack = 1'b1;
    for (int i = 0; i < 4; i++) begin
      imem_rdata = words[i];
      check($sformatf("seq_addr%0d", i), imem_addr, 64'(i * 4));
      check($sformatf("seq_req%0d", i), imem_req, 1'b1);
      check($sformatf("seq_nv%0d", i), instr_valid, 1'b0);
      tick();
      check($sformatf("seq_valid%0d", i), instr_valid, 1'b1);
      check($sformatf("seq_instr%0d", i), instr, words[i]);
      check($sformatf("seq_op%0d", i), opcode, ops[i]);
      check($sformatf("seq_hreq%0d", i), imem_req, 1'b0);
      imem_rdata = 32'hFFFF_FFFF;
      tick();
    end
    retire = 1'b0;
    imem_ack = 1'b0;
    check("seq_end_pc", pc, 64'h10);
    // ADD with three wait cycles
    for (int i = 0; i < 3; i++) begin
      check($sformatf("wait_nv%0d", i), instr_valid, 1'b0);
      check($sformatf("wait_req%0d", i), imem_req, 1'b1);
      tick();
    end
    check("wait_nv3", instr_valid, 1'b0);
    fetch(32'h8B020020);
    check("add_valid", instr_valid, 1'b1);
    check("add_op", opcode, 11'b10001011000);
    imem_ack = 1'b1;
    imem_rdata = 32'h1234_5678;
    tick();
    tick();
    imem_ack = 1'b0;
    check("add_hold_op", opcode, 11'b10001011000);
    check("add_hold_instr", instr, 32'h8B020020);
    check("add_hold_pc", pc, 64'h10);
    // branches
    retire_to("br_100", 1'b1, 64'h3C, 64'h100);
    fetch(32'h0);
    retire_to("br_m2", 1'b1, -64'sd2, 64'hF8);
    fetch(32'h0);
    retire_to("br_back", 1'b1, 64'h2, 64'h100);
    fetch(32'h0);
    retire_to("br_p5", 1'b1, 64'h5, 64'h114);
    fetch(32'h0);
    retire_to("br_top", 1'b1, -64'sd70, 64'hFFFF_FFFF_FFFF_FFFC);
    fetch(32'h0);
    retire_to("wrap", 1'b0, 64'h7, 64'h0);
    fetch(32'h0);
    retire = 1'b1;
    retire_to("to_40", 1'b1, 64'h10, 64'h40);
    check("req_ignores_retire", pc, 64'h40);
    fetch(32'hF84003E1);
    check("hold40_valid", instr_valid, 1'b1);
    // asynchronous reset in HOLD
    #2 reset = 1'b1;
    #1;
    check("arst_pc", pc, 64'h0);
    check("arst_instr", instr, 32'h0);
    check("arst_opcode", opcode, 11'h0);
    check("arst_valid", instr_valid, 1'b0);
    check("arst_req", imem_req, 1'b0);
    tick();
    reset = 1'b0;
    imem_ack = 1'b1;
    imem_rdata = 32'hDEAD_BEEF;
    tick();
    imem_ack = 1'b0;
    check("stale_valid", instr_valid, 1'b0);
    check("stale_instr", instr, 32'h0);
    check("post_rst_addr", imem_addr, 64'h0);
    check("post_rst_req", imem_req, 1'b1);
    fetch(32'hCB030041);
    check("post_rst_op", opcode, 11'h658);
`ifdef FETCH_TIMEOUT_EN
    retire_to("to_req", 1'b0, 64'h0, 64'h4);
    for (int i = 0; i < 15; i++) tick();
    check("to_pre_err", fetch_err, 1'b0);
    check("to_pre_req", imem_req, 1'b1);
    tick();
    check("to_err", fetch_err, 1'b1);
    check("to_err_req", imem_req, 1'b0);
    check("to_err_valid", instr_valid, 1'b0);
    imem_ack = 1'b1;
    tick();
    tick();
    imem_ack = 1'b0;
    check("to_sticky", fetch_err, 1'b1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("to_rst_err", fetch_err, 1'b0);
    tick();
    for (int i = 0; i < 15; i++) tick();
    fetch(32'h8B020020);
    check("to_late_valid", instr_valid, 1'b1);
    check("to_late_err", fetch_err, 1'b0);
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
